// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 960,
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int CW = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       start,
  input  logic [7:0] di,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2ClkI,
  input  logic       ps2DatI,
  output logic       ps2ClkOe,
  output logic       ps2DatOe
);

  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAITIDLE} state_t;

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INHIBIT_RTS  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, stateNext;
  logic [CW-1:0] tickCnt, tickCntNext;
  logic [3:0]    bitIdx, bitIdxNext;
  logic [9:0]    frame, frameNext;
  logic          clkOeNext, datOeNext, doneNext, errorNext;
  logic [1:0]    clkSync, datSync;
  logic          clkPrev;
  logic          clkS, datS, fallEdge, timedOut;

  assign clkS     = clkSync[1];
  assign datS     = datSync[1];
  assign fallEdge = ce && clkPrev && !clkS;
  assign timedOut = (tickCnt == TIMEOUT_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    clkSync <= {clkSync[0], ps2ClkI};
    datSync <= {datSync[0], ps2DatI};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitIdx   <= '0;
      frame    <= '0;
      ps2ClkOe <= 1'b0;
      ps2DatOe <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      clkPrev  <= 1'b1;
    end else begin
      state    <= stateNext;
      tickCnt  <= tickCntNext;
      bitIdx   <= bitIdxNext;
      frame    <= frameNext;
      ps2ClkOe <= clkOeNext;
      ps2DatOe <= datOeNext;
      done     <= doneNext;
      error    <= errorNext;
      if (ce) clkPrev <= clkS;
    end
  end

  always_comb begin
    stateNext   = state;
    tickCntNext = tickCnt;
    bitIdxNext  = bitIdx;
    frameNext   = frame;
    clkOeNext   = ps2ClkOe;
    datOeNext   = ps2DatOe;
    doneNext    = 1'b0;
    errorNext   = 1'b0;
    if (ce) begin
      case (state)
        IDLE: begin
          if (start) begin
            // stop, parity and data shifted out LSB first
            frameNext   = {1'b1, ~^di, di};
            tickCntNext = '0;
            bitIdxNext  = '0;
            clkOeNext   = 1'b1;
            datOeNext   = 1'b0;
            stateNext   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (tickCnt == INHIBIT_LAST) begin
            clkOeNext   = 1'b0;
            tickCntNext = '0;
            bitIdxNext  = '0;
            stateNext   = SEND;
          end else begin
            if (tickCnt == INHIBIT_RTS) datOeNext = 1'b1;
            tickCntNext = tickCnt + CW'(1);
          end
        end
        SEND: begin
          if (fallEdge) begin
            tickCntNext = '0;
            bitIdxNext  = bitIdx + 4'd1;
            datOeNext   = ~frame[0];
            frameNext   = {1'b1, frame[9:1]};
            if (bitIdx == 4'd9) stateNext = ACK;
          end else if (timedOut) begin
            datOeNext   = 1'b0;
            clkOeNext   = 1'b0;
            errorNext   = 1'b1;
            tickCntNext = '0;
            stateNext   = IDLE;
          end else begin
            tickCntNext = tickCnt + CW'(1);
          end
        end
        ACK: begin
          if (fallEdge) begin
            tickCntNext = '0;
            if (!datS) begin
              stateNext = WAITIDLE;
            end else begin
              errorNext = 1'b1;
              stateNext = IDLE;
            end
          end else if (timedOut) begin
            datOeNext   = 1'b0;
            clkOeNext   = 1'b0;
            errorNext   = 1'b1;
            tickCntNext = '0;
            stateNext   = IDLE;
          end else begin
            tickCntNext = tickCnt + CW'(1);
          end
        end
        WAITIDLE: begin
          if (clkS && datS) begin
            doneNext    = 1'b1;
            tickCntNext = '0;
            stateNext   = IDLE;
          end else if (timedOut) begin
            datOeNext   = 1'b0;
            clkOeNext   = 1'b0;
            errorNext   = 1'b1;
            tickCntNext = '0;
            stateNext   = IDLE;
          end else begin
            tickCntNext = tickCnt + CW'(1);
          end
        end
        default: begin
          clkOeNext = 1'b0;
          datOeNext = 1'b0;
          stateNext = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the outgoing counterpart of the keyboard receive path. It sends one command byte to the keyboard, for example LED set (0xED) or reset (0xFF), using the standard host-request sequence: inhibit, request-to-send, 8 data bits, odd parity, stop bit, and a device ACK. It drives the shared open-collector ps2 clock and data lines through active-high pull-low enables, alongside the existing receive logic at top level.

Parameters:
INHIBIT_CYCLES, 960, number of ce ticks the clock line is held low before request-to-send (120 us at 8 MHz ce).
TIMEOUT_CYCLES, 16000, number of ce ticks allowed between device clock falling edges, and for final line-idle, before aborting (2 ms at 8 MHz ce).
CW, 14, width of the tick counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
clock  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
ce  input  1  tick enable; all counters and state advance only when ce=1
start  input  1  request to send; accepted only in IDLE (sampled on ce)
di  input  8  byte to send; latched on start acceptance
busy  output  1  high from acceptance until return to IDLE
done  output  1  one-clock pulse (first clock after the ce tick of completion) on successful ACK
error  output  1  one-clock pulse on timeout or NACK
ps2ClkI  input  1  ps2 clock line level (asynchronous)
ps2DatI  input  1  ps2 data line level (asynchronous)
ps2ClkOe  output  1  1 = pull ps2 clock low
ps2DatOe  output  1  1 = pull ps2 data low

Behaviour:
- Reset values: busy=0, done=0, error=0, ps2ClkOe=0, ps2DatOe=0, state=IDLE, counters=0.
- Reset has priority over everything; a reset mid-transfer releases both lines on the next clock edge and returns to IDLE with no done or error pulse.
- Synchronisation and edge detect:
  - ps2ClkI and ps2DatI pass through a 2-flop synchroniser clocked on every clock, not gated by ce.
  - A falling edge means a synchronised clock of 1 then 0, evaluated on ce ticks only.
- Parity bit = ~^di (odd parity).
- States:
  - IDLE: lines released. On start=1 (ce=1): latch di, compute parity, busy=1, ps2ClkOe=1, clear counter, go to INHIBIT. Start in any other state is ignored.
  - INHIBIT: hold ps2ClkOe=1 for INHIBIT_CYCLES ticks. On the final tick, set ps2DatOe=1 (start bit 0), then on the next tick ps2ClkOe=0 and go to SEND with bit index 0. Falling edges seen in this state are ignored.
  - SEND: on each falling edge, drive the next bit (ps2DatOe = ~bit):
    - edges 1-8 carry D0..D7, LSB first;
    - edge 9 carries parity;
    - edge 10 carries the stop bit (ps2DatOe=0);
    - after edge 10, go to ACK.
  - ACK: on the next falling edge, sample synchronised data. 0 means go to WAITIDLE; 1 means NACK, so pulse error and go to IDLE.
  - WAITIDLE: wait until synchronised clock=1 and data=1, then pulse done and go to IDLE (busy=0 in the same cycle).
- Timeout:
  - In SEND, ACK and WAITIDLE, the tick counter restarts on each falling edge (or on entry) and increments on every ce tick.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses error and returns to IDLE.
  - Bit position is a 4-bit counter 0..10; wrap-around cannot occur because the state leaves SEND at 10.
- Timing: busy, ps2ClkOe and ps2DatOe change only on clock edges with ce=1.
  - A driven bit appears one ce tick after the detected edge, plus 2 clocks of synchroniser latency; this is well within the device's clock-low half-period.
  - Back-to-back transfers are allowed: start is accepted on the first ce tick in IDLE after done or error.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that ACKs:
  - ps2ClkOe low for exactly 960 ticks;
  - data bits 1,0,1,1,0,1,1,1 observed at device rising edges, then parity 1 and stop 1;
  - ACK sampled 0, lines idle, done pulses once, busy falls the same cycle, error stays 0.
- Send 0x00 with a device that never clocks after the release: error pulses after 16000 ticks, both Oe outputs are 0 and busy is 0.
- Send 0xFF with the device holding data high at the ACK edge: parity bit 1 observed, then error pulses (NACK) and done stays 0.
- Assert reset for one clock at bit index 5 of a transfer: the next clock has ps2ClkOe=0, ps2DatOe=0 and busy=0; a new start then runs a complete transfer correctly.
- Pulse start during an active transfer with a different di: it is ignored and the original byte is transmitted intact. Assert start together with reset: the request is not accepted and state stays IDLE.
- Run with ce=0 for long stretches mid-transfer: there is no state, counter or output change during ce=0, and the transfer completes normally once ce resumes.
